// File: rtl/game_pkg.sv
// Shared constants and types for the falling-object game: lane x positions,
// judgement row, score width and the player-side FSM states.
package game_pkg;

    localparam logic [8:0] CAR_Y     = 9'd390;
    localparam int         SCORE_W   = 8;

    localparam logic [9:0] LANE_L0_X = 10'd259;
    localparam logic [9:0] LANE_L1_X = 10'd299;
    localparam logic [9:0] LANE_R0_X = 10'd339;
    localparam logic [9:0] LANE_R1_X = 10'd378;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    // Adds two to the score, clamping at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] score_add2(input logic [SCORE_W-1:0] s);
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + (SCORE_W+1)'(2);
        return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/collision_monitor_if.sv
// Bundles the gamepad/object-generator inputs and the renderer-facing outputs
// of collision_monitor; master drives the inputs, slave is the monitor itself.
interface collision_monitor_if;
    import game_pkg::*;

    logic                active;
    logic                btn_l;
    logic                btn_r;
    logic                object_generated;
    logic [8:0]          object_y;
    logic                object_is_square;
    logic                object_is_square2;
    logic                path;
    logic                path2;

    logic                end_game;
    logic [SCORE_W-1:0]  score;
    logic                car_path;
    logic                car_path2;
    logic [9:0]          car_x;
    logic [9:0]          car_x2;

    modport master (
        output active, btn_l, btn_r, object_generated, object_y,
               object_is_square, object_is_square2, path, path2,
        input  end_game, score, car_path, car_path2, car_x, car_x2
    );

    modport slave (
        input  active, btn_l, btn_r, object_generated, object_y,
               object_is_square, object_is_square2, path, path2,
        output end_game, score, car_path, car_path2, car_x, car_x2
    );

endinterface

// File: rtl/lane_toggle.sv
// One car's lane: rising-edge detect on a debounced button, lane toggle flop
// (only while enabled) and a registered x position one cycle behind the lane.
module lane_toggle #(
    parameter logic [9:0] X0 = 10'd0,
    parameter logic [9:0] X1 = 10'd0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       btn_i,
    output logic       path_o,
    output logic [9:0] x_o
);

    logic       btn_q;
    logic       path_q, path_d;
    logic [9:0] x_q,    x_d;

    always_comb begin
        path_d = path_q;
        if (en_i && btn_i && !btn_q) begin
            path_d = ~path_q;
        end
        x_d = path_q ? X1 : X0;
    end

    // The edge register tracks the button even when disabled, so a press held
    // across entering PLAY does not register as a fresh edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_q  <= 1'b0;
            path_q <= 1'b0;
            x_q    <= X0;
        end else begin
            btn_q  <= btn_i;
            path_q <= path_d;
            x_q    <= x_d;
        end
    end

    assign path_o = path_q;
    assign x_o    = x_q;

endmodule

// File: rtl/collision_monitor.sv
// Player-side game logic: car lanes from buttons, per-object judgement at the
// car row, sticky end_game on crash/miss and a saturating score.
module collision_monitor
    import game_pkg::*;
(
    input  logic                pix_stb1,
    input  logic                RST,
    collision_monitor_if.slave  bus
);

    state_t             state_q, state_d;
    logic               judged_q, judged_d;
    logic               end_game_q, end_game_d;
    logic [SCORE_W-1:0] score_q, score_d;

    logic car_path, car_path2;
    logic judge, fail1, fail2, fail;
    logic playing;

    assign playing = (state_q == PLAY);

    lane_toggle #(.X0(LANE_L0_X), .X1(LANE_L1_X)) u_lane_l (
        .clk_i  (pix_stb1),
        .rst_i  (RST),
        .en_i   (playing),
        .btn_i  (bus.btn_l),
        .path_o (car_path),
        .x_o    (bus.car_x)
    );

    lane_toggle #(.X0(LANE_R0_X), .X1(LANE_R1_X)) u_lane_r (
        .clk_i  (pix_stb1),
        .rst_i  (RST),
        .en_i   (playing),
        .btn_i  (bus.btn_r),
        .path_o (car_path2),
        .x_o    (bus.car_x2)
    );

    // Judgement uses the registered lanes, so a same-cycle button edge only
    // affects the next object.
    always_comb begin
        judge = playing && bus.object_generated && (bus.object_y >= CAR_Y) && !judged_q;
        fail1 = bus.object_is_square  ? (bus.path  == car_path)  : (bus.path  != car_path);
        fail2 = bus.object_is_square2 ? (bus.path2 == car_path2) : (bus.path2 != car_path2);
        fail  = fail1 || fail2;
    end

    always_comb begin
        state_d    = state_q;
        judged_d   = judged_q;
        end_game_d = end_game_q;
        score_d    = score_q;

        unique case (state_q)
            IDLE: if (bus.active) state_d = PLAY;
            PLAY: begin
                if (judge && fail) begin
                    state_d = OVER;
                end else if (!bus.active) begin
                    state_d = IDLE;
                end
            end
            OVER:    state_d = OVER;
            default: state_d = IDLE;
        endcase

        if (judge) begin
            if (fail) begin
                end_game_d = 1'b1;
            end else begin
                score_d  = score_add2(score_q);
                judged_d = 1'b1;
            end
        end

        if (!bus.object_generated || (bus.object_y < CAR_Y)) begin
            judged_d = 1'b0;
        end
    end

    always_ff @(posedge pix_stb1) begin
        if (RST) begin
            state_q    <= IDLE;
            judged_q   <= 1'b0;
            end_game_q <= 1'b0;
            score_q    <= '0;
        end else begin
            state_q    <= state_d;
            judged_q   <= judged_d;
            end_game_q <= end_game_d;
            score_q    <= score_d;
        end
    end

    assign bus.end_game  = end_game_q;
    assign bus.score     = score_q;
    assign bus.car_path  = car_path;
    assign bus.car_path2 = car_path2;

endmodule

// File: tb/tb_collision_monitor.sv
// Scoreboard bench for collision_monitor: directed game scenarios followed by
// randomized play, checked every cycle against a game-rule reference model.
module tb_collision_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    collision_monitor_if bus();

    collision_monitor dut (
        .pix_stb1 (clk),
        .RST      (rst),
        .bus      (bus)
    );

    typedef struct {
        bit end_game;
        int score;
        bit cp1;
        bit cp2;
        int x1;
        int x2;
    } exp_t;

    exp_t exp_q[$];
    int tests  = 0;
    int failed = 0;

    // Reference model: the game as seen by the player.
    int m_mode;           // 0 = waiting, 1 = playing, 2 = game over
    bit m_lane1, m_lane2;
    bit m_prev_bl, m_prev_br;
    bit m_counted;        // current object already scored
    bit m_over;
    int m_score;
    int m_x1, m_x2;

    function automatic int lane_x(input bit right, input bit lane);
        if (!right) return lane ? 299 : 259;
        return lane ? 378 : 339;
    endfunction

    task automatic model(input bit r, a, bl, br, g, input int y,
                         input bit s1, s2, p1, p2);
        bit at_row, ok;
        int nx1, nx2;
        if (r) begin
            m_mode = 0; m_lane1 = 0; m_lane2 = 0; m_prev_bl = 0; m_prev_br = 0;
            m_counted = 0; m_over = 0; m_score = 0; m_x1 = 259; m_x2 = 339;
            return;
        end
        at_row = (m_mode == 1) && g && (y >= 390) && !m_counted;
        // a square must be dodged, a circle must be under the car
        ok = (s1 ? (p1 != m_lane1) : (p1 == m_lane1)) &&
             (s2 ? (p2 != m_lane2) : (p2 == m_lane2));
        nx1 = lane_x(0, m_lane1);
        nx2 = lane_x(1, m_lane2);
        if (m_mode == 1) begin
            if (bl && !m_prev_bl) m_lane1 = !m_lane1;
            if (br && !m_prev_br) m_lane2 = !m_lane2;
        end
        m_prev_bl = bl;
        m_prev_br = br;
        if (at_row && !ok) begin
            m_over = 1;
            m_mode = 2;
        end else begin
            if (at_row) begin
                m_score   = (m_score + 2 > 255) ? 255 : m_score + 2;
                m_counted = 1;
            end
            if (m_mode == 0 && a) m_mode = 1;
            else if (m_mode == 1 && !a) m_mode = 0;
        end
        if (!g || y < 390) m_counted = 0;
        m_x1 = nx1;
        m_x2 = nx2;
    endtask

    task automatic tick(input bit r, a, bl, br, g, input int y,
                        input bit s1, s2, p1, p2);
        exp_t e;
        rst                   = r;
        bus.active            = a;
        bus.btn_l             = bl;
        bus.btn_r             = br;
        bus.object_generated  = g;
        bus.object_y          = 9'(y);
        bus.object_is_square  = s1;
        bus.object_is_square2 = s2;
        bus.path              = p1;
        bus.path2             = p2;
        model(r, a, bl, br, g, y, s1, s2, p1, p2);
        e.end_game = m_over;
        e.score    = m_score;
        e.cp1      = m_lane1;
        e.cp2      = m_lane2;
        e.x1       = m_x1;
        e.x2       = m_x2;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_tick(input bit r, a);
        tick(r, a, 0, 0, 0, 9, 0, 0, 0, 0);
    endtask

    // Object pair at y that both pass against the model's current lanes.
    task automatic pass_tick(input bit bl, input int y);
        bit s1, s2;
        s1 = 1'($urandom_range(0, 1));
        s2 = 1'($urandom_range(0, 1));
        tick(0, 1, bl, 0, 1, y, s1, s2, s1 ? !m_lane1 : m_lane1, s2 ? !m_lane2 : m_lane2);
    endtask

    // Monitor: every clock edge the DUT presents a new output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                tests++;
                if (bus.end_game !== e.end_game || int'(bus.score) != e.score ||
                    bus.car_path !== e.cp1 || bus.car_path2 !== e.cp2 ||
                    int'(bus.car_x) != e.x1 || int'(bus.car_x2) != e.x2 ||
                    $isunknown({bus.end_game, bus.score, bus.car_x, bus.car_x2})) begin
                    failed++;
                    $display("FAIL outputs @%0t: got end=%b score=%0d cp=%b/%b x=%0d/%0d, want end=%b score=%0d cp=%b/%b x=%0d/%0d",
                             $time, bus.end_game, bus.score, bus.car_path, bus.car_path2,
                             bus.car_x, bus.car_x2, e.end_game, e.score, e.cp1, e.cp2, e.x1, e.x2);
                end
            end
        end
    end

    initial begin
        bit r, a, g;
        int y;
        @(negedge clk);

        // reset, then a button press while waiting is ignored
        repeat (3) idle_tick(1, 0);
        tick(0, 0, 1, 1, 0, 9, 0, 0, 0, 0);
        repeat (2) idle_tick(0, 0);

        // double pass on a full descent: score +2 once
        idle_tick(0, 1);
        for (int yy = 9; yy <= 400; yy++) tick(0, 1, 0, 0, 1, yy, 0, 1, 0, 1);
        idle_tick(0, 1);

        // crash on a square; end_game survives object_generated dropping
        for (int yy = 385; yy <= 392; yy++) tick(0, 1, 0, 0, 1, yy, 1, 0, 0, 0);
        repeat (4) idle_tick(0, 1);
        tick(0, 1, 1, 1, 1, 395, 0, 0, 0, 0);
        idle_tick(1, 0);
        idle_tick(0, 1);

        // move car1 to lane 1, then toggle on the judge cycle itself
        tick(0, 1, 1, 0, 0, 9, 0, 0, 0, 0);
        idle_tick(0, 1);
        tick(0, 1, 0, 0, 1, 389, 0, 0, 1, 0);
        tick(0, 1, 1, 0, 1, 390, 0, 0, 1, 0);
        tick(0, 1, 0, 0, 1, 391, 0, 0, 1, 0);
        idle_tick(0, 1);

        // pause and resume keeps score
        repeat (2) idle_tick(0, 0);
        idle_tick(0, 1);

        // saturation: keep passing well beyond 255
        for (int k = 0; k < 130; k++) begin
            pass_tick(k % 7 == 3, 395);
            pass_tick(0, 398);
            idle_tick(0, 1);
        end
        // reset on a judge cycle wins
        tick(1, 1, 0, 0, 1, 395, 0, 0, 0, 0);
        idle_tick(0, 1);
        pass_tick(0, 390);
        idle_tick(0, 1);

        // randomized play
        y = 9;
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 59) == 0);
            a = ($urandom_range(0, 19) != 0);
            g = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) y = 9;
            else y = (y + int'($urandom_range(0, 40)) > 511) ? 9 : y + int'($urandom_range(0, 40));
            if ($urandom_range(0, 2) == 0 && !r)
                pass_tick(1'($urandom_range(0, 1)), y);
            else
                tick(r, a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), g, y,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d expected results never checked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
